// File: rtl/rf_pkg.sv
// rf_pkg: shared byte-strobe merge helper for the register file blocks.
package rf_pkg;
  function automatic int strb_width(int data_w);
    return data_w / 8;
  endfunction
  function automatic logic [7:0] strb_merge(logic [7:0] old_b, logic [7:0] new_b, logic en);
    return en ? new_b : old_b;
  endfunction
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port with optional write-to-read bypass.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int BYPASS = 1,
  localparam int DEPTH = 2 ** ADDR_W,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DEPTH*DATA_W-1:0] entries,
  input  logic                    wr_ok,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [STRB_W-1:0]       wr_strb,
  output logic [DATA_W-1:0]       data,
  output logic                    valid
);
  logic [DATA_W-1:0] cur, merged, nxt;
  logic hit;
  assign cur = entries[addr*DATA_W +: DATA_W];
  assign hit = (BYPASS != 0) && wr_ok && (wr_addr == addr);
  always_comb begin
    merged = cur;
    for (int k = 0; k < STRB_W; k++)
      merged[8*k +: 8] = strb_merge(cur[8*k +: 8], wr_data[8*k +: 8], wr_strb[k]);
    nxt = hit ? merged : cur;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) data <= nxt;
    end
endmodule

// File: rtl/register_file_2r1w.sv
// register_file_2r1w: parametrised 1-write / 2-read register file with byte strobes,
// registered reads, optional write bypass and read-only entries.
module register_file_2r1w
  import rf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int BYPASS = 1,
  parameter logic [2**ADDR_W-1:0] RO_MASK = '0,
  parameter logic [(2**ADDR_W)*DATA_W-1:0] RST_VALS = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Wr_Enable,
  input  logic [ADDR_W-1:0] Wr_Address,
  input  logic [DATA_W-1:0] Wr_Data,
  input  logic [DATA_W/8-1:0] Wr_Strb,
  output logic              Wr_Err,
  input  logic              Rd_Enable_A,
  input  logic [ADDR_W-1:0] Rd_Address_A,
  output logic [DATA_W-1:0] Rd_Data_A,
  output logic              Rd_Valid_A,
  input  logic              Rd_Enable_B,
  input  logic [ADDR_W-1:0] Rd_Address_B,
  output logic [DATA_W-1:0] Rd_Data_B,
  output logic              Rd_Valid_B
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int STRB_W = strb_width(DATA_W);
  if (DATA_W % 8 != 0 || $bits(RO_MASK) != DEPTH) begin : g_bad_params
    $error("register_file_2r1w: DATA_W must be a multiple of 8 and RO_MASK DEPTH bits wide");
  end
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH*DATA_W-1:0] entries;
  logic [DATA_W-1:0] wr_word;
  logic wr_ok, wr_ro;
  assign wr_ro = Wr_Enable & RO_MASK[Wr_Address];
  assign wr_ok = Wr_Enable & ~RO_MASK[Wr_Address];
  always_comb begin
    wr_word = mem[Wr_Address];
    for (int k = 0; k < STRB_W; k++)
      wr_word[8*k +: 8] = strb_merge(mem[Wr_Address][8*k +: 8], Wr_Data[8*k +: 8], Wr_Strb[k]);
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VALS[i*DATA_W +: DATA_W];
      Wr_Err <= 1'b0;
    end else begin
      if (wr_ok) mem[Wr_Address] <= wr_word;
      Wr_Err <= wr_ro;
    end
  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign entries[i*DATA_W +: DATA_W] = mem[i];
  end
  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_a (
    .clk(CLK), .rst_n(RST), .en(Rd_Enable_A), .addr(Rd_Address_A), .entries(entries),
    .wr_ok(wr_ok), .wr_addr(Wr_Address), .wr_data(Wr_Data), .wr_strb(Wr_Strb),
    .data(Rd_Data_A), .valid(Rd_Valid_A)
  );
  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_b (
    .clk(CLK), .rst_n(RST), .en(Rd_Enable_B), .addr(Rd_Address_B), .entries(entries),
    .wr_ok(wr_ok), .wr_addr(Wr_Address), .wr_data(Wr_Data), .wr_strb(Wr_Strb),
    .data(Rd_Data_B), .valid(Rd_Valid_B)
  );
endmodule

// File: tb/tb_register_file_2r1w.sv
// tb_register_file_2r1w: directed + random checks of a bypass and a non-bypass build
// against a word-level reference model.
module tb_register_file_2r1w;
  localparam logic [63:0] RV = {16'h0003, 16'h003B, 16'h0000, 16'h0000};
  localparam logic [3:0]  RO = 4'b1000;
  logic CLK, RST, we, ea, eb;
  logic [1:0] wa, aa, ab, ws;
  logic [15:0] wd;
  logic [15:0] rd_a1, rd_b1, rd_a0, rd_b0;
  logic va1, vb1, va0, vb0, err1, err0;
  logic [15:0] m [4];
  logic [15:0] xa1, xb1, xa0, xb0;
  logic xva, xvb, xerr;
  int checks = 0, errors = 0;

  register_file_2r1w #(.DATA_W(16), .ADDR_W(2), .BYPASS(1), .RO_MASK(RO), .RST_VALS(RV)) dut (
    .CLK(CLK), .RST(RST), .Wr_Enable(we), .Wr_Address(wa), .Wr_Data(wd), .Wr_Strb(ws),
    .Wr_Err(err1), .Rd_Enable_A(ea), .Rd_Address_A(aa), .Rd_Data_A(rd_a1), .Rd_Valid_A(va1),
    .Rd_Enable_B(eb), .Rd_Address_B(ab), .Rd_Data_B(rd_b1), .Rd_Valid_B(vb1)
  );
  register_file_2r1w #(.DATA_W(16), .ADDR_W(2), .BYPASS(0), .RO_MASK(RO), .RST_VALS(RV)) dut0 (
    .CLK(CLK), .RST(RST), .Wr_Enable(we), .Wr_Address(wa), .Wr_Data(wd), .Wr_Strb(ws),
    .Wr_Err(err0), .Rd_Enable_A(ea), .Rd_Address_A(aa), .Rd_Data_A(rd_a0), .Rd_Valid_A(va0),
    .Rd_Enable_B(eb), .Rd_Address_B(ab), .Rd_Data_B(rd_b0), .Rd_Valid_B(vb0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] mrg(logic [15:0] o, logic [15:0] n, logic [1:0] s);
    logic [15:0] r;
    r = o;
    if (s[0]) r[7:0] = n[7:0];
    if (s[1]) r[15:8] = n[15:8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_a_byp"}, rd_a1, xa1);
    chk({tag, "_b_byp"}, rd_b1, xb1);
    chk({tag, "_a_nobyp"}, rd_a0, xa0);
    chk({tag, "_b_nobyp"}, rd_b0, xb0);
    chk({tag, "_va"}, {15'd0, va1}, {15'd0, xva});
    chk({tag, "_vb"}, {15'd0, vb1}, {15'd0, xvb});
    chk({tag, "_va0"}, {15'd0, va0}, {15'd0, xva});
    chk({tag, "_vb0"}, {15'd0, vb0}, {15'd0, xvb});
    chk({tag, "_err"}, {15'd0, err1}, {15'd0, xerr});
    chk({tag, "_err0"}, {15'd0, err0}, {15'd0, xerr});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = RV[i*16 +: 16];
    xa1 = '0; xb1 = '0; xa0 = '0; xb0 = '0; xva = 0; xvb = 0; xerr = 0;
  endtask

  // Drives one cycle of stimulus, predicts, then checks just after the edge.
  task automatic step(input string tag, input logic w, input logic [1:0] a, input logic [15:0] d,
                      input logic [1:0] s, input logic ra, input logic [1:0] a_a,
                      input logic rb, input logic [1:0] a_b);
    logic wrote;
    logic [15:0] post;
    we = w; wa = a; wd = d; ws = s; ea = ra; aa = a_a; eb = rb; ab = a_b;
    wrote = w && !RO[a];
    post = wrote ? mrg(m[a], d, s) : m[a];
    if (ra) begin xa0 = m[a_a]; xa1 = (a_a == a) ? post : m[a_a]; end
    if (rb) begin xb0 = m[a_b]; xb1 = (a_b == a) ? post : m[a_b]; end
    xva = ra; xvb = rb; xerr = w && RO[a];
    if (wrote) m[a] = post;
    @(posedge CLK); #1;
    chk_all(tag);
  endtask

  initial begin
    RST = 1'b0; we = 0; wa = 0; wd = 0; ws = 0; ea = 0; aa = 0; eb = 0; ab = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset");
    RST = 1'b1;
    step("t1", 0, 0, 0, 0, 1, 2, 1, 3);
    chk("t1_a_const", rd_a1, 16'h003B);
    chk("t1_b_const", rd_b1, 16'h0003);
    step("t2_w0", 1, 0, 16'hABCD, 2'b01, 0, 0, 0, 0);
    step("t2_r0", 0, 0, 0, 0, 1, 0, 0, 0);
    chk("t2_lo_const", rd_a1, 16'h00CD);
    step("t2_w1", 1, 0, 16'h12FF, 2'b10, 0, 0, 0, 0);
    step("t2_r1", 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t2_hi_const", rd_b1, 16'h12CD);
    step("t3", 1, 1, 16'h1111, 2'b11, 1, 1, 0, 0);
    chk("t3_byp_const", rd_a1, 16'h1111);
    chk("t3_nobyp_const", rd_a0, 16'h0000);
    step("t4_w", 1, 3, 16'hFFFF, 2'b11, 0, 0, 1, 3);
    chk("t4_err_const", {15'd0, err1}, 16'd1);
    chk("t4_rdb_const", rd_b1, 16'h0003);
    step("t4_r", 0, 0, 0, 0, 1, 3, 0, 0);
    chk("t4_err_clr", {15'd0, err1}, 16'd0);
    chk("t4_rd_const", rd_a1, 16'h0003);
    step("t4_nowr", 1, 2, 16'h5A5A, 2'b00, 1, 2, 0, 0);
    chk("t4_strb0_const", rd_a1, 16'h003B);
    step("t6_r", 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("t6_hold", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_hold_const", rd_a1, 16'h12CD);
    end
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom), 2'($urandom), 16'($urandom), 2'($urandom),
           1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom));
    // Reset asserted after the write is presented but before its clock edge.
    we = 1; wa = 0; wd = 16'h5555; ws = 2'b11; ea = 1; aa = 0; eb = 1; ab = 1;
    #3 RST = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    chk_all("t5_rst");
    #2 RST = 1'b1;
    we = 0; ea = 0; eb = 0;
    step("t5_r01", 0, 0, 0, 0, 1, 0, 1, 1);
    chk("t5_e0_const", rd_a1, 16'h0000);
    step("t5_r23", 0, 0, 0, 0, 1, 2, 1, 3);
    chk("t5_e2_const", rd_a1, 16'h003B);
    chk("t5_e3_const", rd_b1, 16'h0003);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
